// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants, FSM encodings and serial step function
package crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One-hot state encodings shared by the CRC generator and checker FSMs
    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_PAYLOAD = 4'b0010,
        ST_CRC     = 4'b0100,
        ST_DONE    = 4'b1000
    } crc_state_t;

    // One MSB-first serial step of a non-reflected CRC-8
    function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                             input logic       din,
                                             input logic [7:0] poly);
        logic fb;
        fb = din ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_check_if.sv
// rtl/crc8_check_if.sv - serial frame input and parallel result bundle of the CRC-8 checker
interface crc8_check_if #(
    parameter int DATA_BITS = 32
);
    logic                 frame_start;
    logic                 data;
    logic                 data_valid;
    logic                 busy;
    logic [DATA_BITS-1:0] payload;
    logic [7:0]           rx_crc;
    logic [7:0]           calc_crc;
    logic                 frame_done;
    logic                 crc_ok;
    logic                 crc_err;

    modport master (
        output frame_start, data, data_valid,
        input  busy, payload, rx_crc, calc_crc, frame_done, crc_ok, crc_err
    );

    modport slave (
        input  frame_start, data, data_valid,
        output busy, payload, rx_crc, calc_crc, frame_done, crc_ok, crc_err
    );
endinterface

// File: rtl/crc8_lfsr.sv
// rtl/crc8_lfsr.sv - serial CRC-8 step register with synchronous clear
module crc8_lfsr
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    // Clear wins over en so a restart never folds in a bit from the old frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc <= INIT;
        end else if (clear) begin
            crc <= INIT;
        end else if (en) begin
            crc <= crc8_step(crc, din, POLY);
        end
    end

endmodule

// File: rtl/crc8_check.sv
// rtl/crc8_check.sv - serial CRC-8 frame receiver and checker
module crc8_check
    import crc_pkg::*;
#(
    parameter int         DATA_BITS = 32,
    parameter logic [7:0] POLY      = CRC8_POLY,
    parameter logic [7:0] INIT      = CRC8_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    crc8_check_if.slave bus
);

    localparam int             CW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);

    crc_state_t           state;
    crc_state_t           state_next;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           crc_cnt;
    logic [DATA_BITS-1:0] payload_r;
    logic [7:0]           rx_crc_r;
    logic [7:0]           calc_crc_w;
    logic                 crc_ok_r;
    logic                 crc_err_r;
    logic                 pay_accept;
    logic                 crc_accept;
    logic                 busy_w;
    logic                 done_w;

    // A bit coinciding with frame_start belongs to neither frame and is dropped
    assign pay_accept = bus.data_valid && !bus.frame_start && (state == ST_PAYLOAD);
    assign crc_accept = bus.data_valid && !bus.frame_start && (state == ST_CRC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_w     = 1'b0;
        done_w     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_next = ST_IDLE;
            end
            ST_PAYLOAD: begin
                busy_w = 1'b1;
                if (pay_accept && (bit_cnt == LAST_BIT)) begin
                    state_next = ST_CRC;
                end
            end
            ST_CRC: begin
                busy_w = 1'b1;
                if (crc_accept && (crc_cnt == 3'd7)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_w     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (bus.frame_start) begin
            state_next = ST_PAYLOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            crc_cnt   <= '0;
            payload_r <= '0;
            rx_crc_r  <= '0;
            crc_ok_r  <= 1'b0;
            crc_err_r <= 1'b0;
        end else if (bus.frame_start) begin
            bit_cnt   <= '0;
            crc_cnt   <= '0;
            crc_ok_r  <= 1'b0;
            crc_err_r <= 1'b0;
        end else if (pay_accept) begin
            payload_r <= (payload_r << 1) | DATA_BITS'(bus.data);
            bit_cnt   <= bit_cnt + 1'b1;
        end else if (crc_accept) begin
            rx_crc_r <= {rx_crc_r[6:0], bus.data};
            crc_cnt  <= crc_cnt + 1'b1;
            // Verdict uses the completed byte, since rx_crc_r lags by one bit here
            if (crc_cnt == 3'd7) begin
                crc_ok_r  <= ({rx_crc_r[6:0], bus.data} == calc_crc_w);
                crc_err_r <= ({rx_crc_r[6:0], bus.data} != calc_crc_w);
            end
        end
    end

    crc8_lfsr #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.frame_start),
        .en    (pay_accept),
        .din   (bus.data),
        .crc   (calc_crc_w)
    );

    assign bus.busy       = busy_w;
    assign bus.frame_done = done_w;
    assign bus.payload    = payload_r;
    assign bus.rx_crc     = rx_crc_r;
    assign bus.calc_crc   = calc_crc_w;
    assign bus.crc_ok     = crc_ok_r;
    assign bus.crc_err    = crc_err_r;

endmodule

// File: tb/tb_crc8_check.sv
// tb/tb_crc8_check.sv - directed-vector self-checking bench for crc8_check
module tb_crc8_check;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   done_cnt;
    int   busy_gap;
    logic in_frame;

    crc8_check_if #(.DATA_BITS(32)) bus ();

    crc8_check #(.DATA_BITS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_done) done_cnt++;
        if (in_frame && !bus.busy) busy_gap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives n bits MSB first; returns at the negedge where the last bit is driven
    task automatic drive_bits(input logic [39:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.data       = bits[i];
            bus.data_valid = 1'b1;
            if (i == n - 1) in_frame = 1'b1;
            if (i == 0) begin
                in_frame = 1'b0;
            end else begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    bus.data_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.data_valid  = 1'b0;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.data_valid  = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_payload"}, bus.payload, 32'd0);
        check({tag, "_rx_crc"}, 32'(bus.rx_crc), 32'd0);
        check({tag, "_calc_crc"}, 32'(bus.calc_crc), 32'd0);
        check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_ok"}, 32'(bus.crc_ok), 32'd0);
        check({tag, "_err"}, 32'(bus.crc_err), 32'd0);
    endtask

    int d0;

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        busy_gap = 0;
        in_frame = 1'b0;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.data        = 1'b0;
        bus.data_valid  = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        idle_cycle();

        // 1: back-to-back bits, good CRC
        d0 = done_cnt;
        pulse_start();
        drive_bits({32'h00000001, 8'h07}, 40, 0);
        check("t1_no_early_done", 32'(bus.frame_done), 32'd0);
        check("t1_busy_last_bit", 32'(bus.busy), 32'd1);
        idle_cycle();
        check("t1_done", 32'(bus.frame_done), 32'd1);
        check("t1_ok", 32'(bus.crc_ok), 32'd1);
        check("t1_err", 32'(bus.crc_err), 32'd0);
        check("t1_calc", 32'(bus.calc_crc), 32'h07);
        check("t1_payload", bus.payload, 32'h00000001);
        check("t1_rx", 32'(bus.rx_crc), 32'h07);
        idle_cycle();
        check("t1_done_pulse", 32'(bus.frame_done), 32'd0);
        check("t1_ok_held", 32'(bus.crc_ok), 32'd1);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);

        // 2: one cycle on, two off; busy must never drop mid-frame
        busy_gap = 0;
        pulse_start();
        check("t2_ok_cleared", 32'(bus.crc_ok), 32'd0);
        drive_bits({32'h00000080, 8'h89}, 40, 2);
        idle_cycle();
        check("t2_done", 32'(bus.frame_done), 32'd1);
        check("t2_ok", 32'(bus.crc_ok), 32'd1);
        check("t2_calc", 32'(bus.calc_crc), 32'h89);
        check("t2_payload", bus.payload, 32'h00000080);
        check("t2_busy_gaps", 32'(busy_gap), 32'd0);
        idle_cycle();

        // 3: corrupted CRC byte
        pulse_start();
        drive_bits({32'h00000002, 8'h0F}, 40, 0);
        idle_cycle();
        check("t3_done", 32'(bus.frame_done), 32'd1);
        check("t3_err", 32'(bus.crc_err), 32'd1);
        check("t3_ok", 32'(bus.crc_ok), 32'd0);
        check("t3_calc", 32'(bus.calc_crc), 32'h0E);
        check("t3_rx", 32'(bus.rx_crc), 32'h0F);
        idle_cycle();

        // 4: restart after 20 payload bits
        d0 = done_cnt;
        pulse_start();
        drive_bits({32'hFFFFFFFF, 8'hFF}, 20, 0);
        pulse_start();
        check("t4_err_cleared", 32'(bus.crc_err), 32'd0);
        drive_bits({32'h00000001, 8'h07}, 40, 0);
        idle_cycle();
        check("t4_ok", 32'(bus.crc_ok), 32'd1);
        check("t4_payload", bus.payload, 32'h00000001);
        repeat (3) idle_cycle();
        check("t4_done_count", 32'(done_cnt - d0), 32'd1);

        // 5: reset inside the CRC field
        d0 = done_cnt;
        pulse_start();
        drive_bits({32'h00000001, 8'h07}, 36, 0);
        @(negedge clk);
        rst_n          = 1'b0;
        bus.data       = 1'b1;
        bus.data_valid = 1'b1;
        @(negedge clk);
        rst_n          = 1'b1;
        bus.data_valid = 1'b0;
        check_zero("t5_after_reset");
        drive_bits({8'h00, 32'hFFFFFFFF}, 12, 0);
        idle_cycle();
        check_zero("t5_ignored");
        check("t5_done_count", 32'(done_cnt - d0), 32'd0);

        // 6: bit alongside frame_start is dropped
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.data        = 1'b1;
        bus.data_valid  = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.data_valid  = 1'b0;
        drive_bits({32'h00000001, 8'h07}, 40, 0);
        check("t6_no_early_done", 32'(bus.frame_done), 32'd0);
        idle_cycle();
        check("t6_done", 32'(bus.frame_done), 32'd1);
        check("t6_ok", 32'(bus.crc_ok), 32'd1);
        check("t6_payload", bus.payload, 32'h00000001);
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
